// File: rtl/topmsb_compare_stage.sv
// topmsb_compare_stage: elastic two-stage pipeline that sits in front of the
// top-MSB evaluation checker.
//   S1 registers the leading-one index, the zero flag and the expected-pair match bit.
//   S2 registers the index relation and holds every out_* value.
// Each stage has its own valid bit, so a full pipeline holds two pairs under backpressure.
// Optional macro TOPMSB_STALL_CNT_EN adds a saturating counter of stalled output cycles.
// Without that macro, stall_count is tied to zero.
module topmsb_compare_stage #(
   parameter int W  = 4,
   parameter int IW = 2,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  num1,
   input  logic [W-1:0]  num2,
   input  logic [W-1:0]  a_num1,
   input  logic [W-1:0]  a_num2,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_msb1,
   output logic [IW-1:0] out_msb2,
   output logic          out_zero1,
   output logic          out_zero2,
   output logic [1:0]    out_rel,
   output logic          out_match,
   output logic [CW-1:0] err_count,
   output logic [CW-1:0] stall_count
);

   typedef struct packed {
      logic [IW-1:0] msb1;
      logic [IW-1:0] msb2;
      logic          zero1;
      logic          zero2;
      logic          match;
   } s1_t;

   localparam logic [CW-1:0] CMAX = '1;

   // The highest set bit wins. A zero operand yields index 0.
   function automatic logic [IW-1:0] lead_one(input logic [W-1:0] v);
      lead_one = '0;
      for (int i = 0; i < W; i++)
         if (v[i]) lead_one = IW'(i);
   endfunction

   s1_t          s1_d, s1_q;
   logic         s1_valid;
   logic         s2_load, s1_advance, in_xfer, out_xfer;
   logic [1:0]   rel_d;

   assign s2_load    = !out_valid || out_ready;
   assign s1_advance = s1_valid && s2_load;
   assign in_ready   = !s1_valid || s1_advance;
   assign in_xfer    = in_valid && in_ready;
   assign out_xfer   = out_valid && out_ready;

   // S1 payload: the wide operand compares happen here, off the output path.
   always_comb begin
      s1_d       = '0;
      s1_d.msb1  = lead_one(num1);
      s1_d.msb2  = lead_one(num2);
      s1_d.zero1 = (num1 == '0);
      s1_d.zero2 = (num2 == '0);
      s1_d.match = (num1 == a_num1) && (num2 == a_num2);
   end

   // Relation from the narrow S1 fields. A zero operand ranks below any nonzero operand.
   always_comb begin
      rel_d = 2'b00;
      if (s1_q.zero1 && s1_q.zero2)  rel_d = 2'b00;
      else if (s1_q.zero1)           rel_d = 2'b10;
      else if (s1_q.zero2)           rel_d = 2'b01;
      else if (s1_q.msb1 > s1_q.msb2) rel_d = 2'b01;
      else if (s1_q.msb1 < s1_q.msb2) rel_d = 2'b10;
   end

   // S1 register: load on an input transfer, empty when it advances without a refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else begin
         s1_valid <= in_xfer || (s1_valid && !s1_advance);
         if (in_xfer) s1_q <= s1_d;
      end
   end

   // S2 register: refill from S1 whenever S2 is empty or draining this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_msb1  <= '0;
         out_msb2  <= '0;
         out_zero1 <= 1'b0;
         out_zero2 <= 1'b0;
         out_rel   <= 2'b00;
         out_match <= 1'b0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_msb1  <= s1_q.msb1;
            out_msb2  <= s1_q.msb2;
            out_zero1 <= s1_q.zero1;
            out_zero2 <= s1_q.zero2;
            out_rel   <= rel_d;
            out_match <= s1_q.match;
         end
      end
   end

   // Saturating count of non-matching results that actually left the stage.
   always_ff @(posedge clk) begin
      if (rst)
         err_count <= '0;
      else if (out_xfer && !out_match && err_count != CMAX)
         err_count <= err_count + 1'b1;
   end

`ifdef TOPMSB_STALL_CNT_EN
   // Saturating count of cycles where a result waits on downstream.
   always_ff @(posedge clk) begin
      if (rst)
         stall_count <= '0;
      else if (out_valid && !out_ready && stall_count != CMAX)
         stall_count <= stall_count + 1'b1;
   end
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_topmsb_compare_stage.sv
// Bench for topmsb_compare_stage.
// A queue-based reference model tracks the expected output, checked every cycle.
// Hand-computed literal checks pin down specific cases.
module tb_topmsb_compare_stage;
   localparam int W  = 4;
   localparam int IW = 2;
   localparam int CW = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  num1 = '0, num2 = '0, a_num1 = '0, a_num2 = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [IW-1:0] out_msb1, out_msb2;
   logic          out_zero1, out_zero2;
   logic [1:0]    out_rel;
   logic          out_match;
   logic [CW-1:0] err_count, stall_count;

   topmsb_compare_stage #(.W(W), .IW(IW), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .num1(num1), .num2(num2), .a_num1(a_num1), .a_num2(a_num2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_msb1(out_msb1), .out_msb2(out_msb2),
      .out_zero1(out_zero1), .out_zero2(out_zero2),
      .out_rel(out_rel), .out_match(out_match),
      .err_count(err_count), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int       t;
      int       msb1, msb2;
      bit       z1, z2, match;
      int       rel;
   } res_t;

   res_t q[$];
   int   cyc = 0;
   int   m_err = 0;
   int   m_stall = 0;
   bit   chk_en = 0;

   function automatic int topbit(input int v);
      int p = 0;
      if (v == 0) return -1;
      while (v > 1) begin v = v >> 1; p++; end
      return p;
   endfunction

   function automatic res_t expect_of(input int n1, input int n2, input int a1, input int a2, input int t);
      res_t r;
      int p1 = topbit(n1);
      int p2 = topbit(n2);
      r.t     = t;
      r.z1    = (n1 == 0);
      r.z2    = (n2 == 0);
      r.msb1  = r.z1 ? 0 : p1;
      r.msb2  = r.z2 ? 0 : p2;
      r.rel   = (p1 > p2) ? 1 : (p1 < p2) ? 2 : 0;
      r.match = (n1 == a1) && (n2 == a2);
      return r;
   endfunction

   // Compare the DUT against the model, then advance the model across the next edge.
   always @(negedge clk) begin
      bit mov, mir, ixf, oxf;
      int exp_stall;
      mov = (q.size() > 0) && (cyc >= q[0].t + 1);
      mir = (q.size() < 2) || out_ready;
`ifdef TOPMSB_STALL_CNT_EN
      exp_stall = m_stall;
`else
      exp_stall = 0;
`endif
      if (chk_en) begin
         chk("in_ready", in_ready, mir);
         chk("out_valid", out_valid, mov);
         chk("err_count", err_count, m_err);
         chk("stall_count", stall_count, exp_stall);
         if (mov) begin
            chk("out_msb1", out_msb1, q[0].msb1);
            chk("out_msb2", out_msb2, q[0].msb2);
            chk("out_zero1", out_zero1, q[0].z1);
            chk("out_zero2", out_zero2, q[0].z2);
            chk("out_rel", out_rel, q[0].rel);
            chk("out_match", out_match, q[0].match);
         end
      end
      ixf = in_valid && mir;
      oxf = mov && out_ready;
      cyc++;
      if (rst) begin
         q.delete();
         m_err = 0;
         m_stall = 0;
         chk_en = 1;
      end else begin
         if (mov && !out_ready && m_stall < CMAX) m_stall++;
         if (oxf) begin
            if (!q[0].match && m_err < CMAX) m_err++;
            void'(q.pop_front());
         end
         if (ixf) q.push_back(expect_of(int'(num1), int'(num2), int'(a_num1), int'(a_num2), cyc));
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_pair(input logic [W-1:0] n1, input logic [W-1:0] n2,
                           input logic [W-1:0] e1, input logic [W-1:0] e2);
      num1 = n1; num2 = n2; a_num1 = e1; a_num2 = e2;
   endtask

   // One transfer into an empty pipeline with out_ready=1, then literal checks two edges later.
   task automatic send_lit(input logic [W-1:0] n1, input logic [W-1:0] n2,
                           input logic [W-1:0] e1, input logic [W-1:0] e2,
                           input int m1, input int m2, input int rel, input bit match);
      @(posedge clk); #1;
      in_valid = 1'b1; set_pair(n1, n2, e1, e2);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("lit_valid", out_valid, 1'b1);
      chk("lit_msb1", out_msb1, m1);
      chk("lit_msb2", out_msb2, m2);
      chk("lit_rel", out_rel, rel);
      chk("lit_match", out_match, match);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_msb", {out_msb1, out_msb2}, 0);
      chk("rst_zero", {out_zero1, out_zero2}, 0);
      chk("rst_rel", out_rel, 0);
      chk("rst_match", out_match, 0);
      chk("rst_err", err_count, 0);
      chk("rst_stall", stall_count, 0);

      // Single pair and relation corners.
      send_lit(4'b0001, 4'b0010, 4'b0001, 4'b0010, 0, 1, 2'b10, 1'b1);
      chk("single_err", err_count, 0);
      send_lit(4'b1000, 4'b1111, 4'b1000, 4'b1111, 3, 3, 2'b00, 1'b1);
      send_lit(4'b0000, 4'b0001, 4'b0000, 4'b0001, 0, 0, 2'b10, 1'b1);
      chk("corner_zero1", out_zero1, 1'b1);
      send_lit(4'b0100, 4'b0011, 4'b0100, 4'b0011, 2, 1, 2'b01, 1'b1);

      // Streaming mismatches: 20 transfers, the counter saturates at 7.
      @(posedge clk); #1;
      in_valid = 1'b1; set_pair(4'b0000, 4'b0000, 4'b0001, 4'b0010);
      repeat (20) @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("sat_err", err_count, 7);
      send_lit(4'b0001, 4'b0010, 4'b0001, 4'b0010, 0, 1, 2'b10, 1'b1);
      @(posedge clk); @(negedge clk);
      chk("match_no_inc", err_count, 7);

      // Backpressure: the third pair must wait until downstream accepts.
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1; set_pair(4'b1000, 4'b1111, 4'b0, 4'b0);
      @(posedge clk); #1;
      set_pair(4'b0000, 4'b0001, 4'b0000, 4'b0001);
      @(posedge clk); #1;
      set_pair(4'b0100, 4'b0011, 4'b0100, 4'b0011);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_head_msb1", out_msb1, 3);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);

      // Random traffic.
      repeat (600) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         num1 = W'($urandom);
         num2 = W'($urandom);
         a_num1 = ($urandom_range(0, 1) != 0) ? num1 : W'($urandom);
         a_num2 = ($urandom_range(0, 1) != 0) ? num2 : W'($urandom);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) @(posedge clk);

      // Reset with both stages full. Data offered during reset must be dropped.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1;
      set_pair(4'b0110, 4'b0001, 4'b0000, 4'b0000);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      set_pair(4'b1111, 4'b1111, 4'b0000, 4'b0000);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_err", err_count, 0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("midrst_nothing_captured", out_valid, 1'b0);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
